// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the DSP multiply-accumulate BEL: configuration
// bit positions and a helper that produces accumulator range bounds.
package dsp_mac_pkg;

    localparam int CFG_AREG        = 0;
    localparam int CFG_BREG        = 1;
    localparam int CFG_SIGNED      = 2;
    localparam int CFG_ACC_EN      = 3;
    localparam int CFG_CASC_EN     = 4;
    localparam int CFG_SAT         = 5;
    localparam int NUM_CONFIG_BITS = 6;

    // Width of the bound values; wide enough for any practical accumulator.
    localparam int BOUND_W = 64;

    typedef struct packed {
        logic [BOUND_W-1:0] min_v;
        logic [BOUND_W-1:0] max_v;
    } acc_bounds_t;

    // Smallest and largest representable values of a width-bit accumulator,
    // as two's complement numbers in BOUND_W bits.
    function automatic acc_bounds_t acc_bounds(input int width, input logic is_signed);
        acc_bounds_t        b;
        logic [BOUND_W-1:0] one;
        one = BOUND_W'(1);
        if (is_signed) begin
            b.max_v = (one << (width - 1)) - one;
            b.min_v = ~b.max_v;
        end else begin
            b.max_v = (one << width) - one;
            b.min_v = '0;
        end
        return b;
    endfunction

endpackage

// File: rtl/dsp_mac_addsat.sv
// Three-operand adder with range check and optional clamp to the nearest
// accumulator bound. Purely combinational.
module dsp_mac_addsat
    import dsp_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 20
) (
    input  logic [ACC_WIDTH-1:0] op_a,
    input  logic [ACC_WIDTH-1:0] op_b,
    input  logic [ACC_WIDTH-1:0] op_c,
    input  logic                 is_signed,
    input  logic                 sat_en,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 ovf
);

    // Two guard bits hold any sum of three ACC_WIDTH operands exactly.
    localparam int SW = ACC_WIDTH + 2;

    logic [SW-1:0]      ext_a;
    logic [SW-1:0]      ext_b;
    logic [SW-1:0]      ext_c;
    logic [SW-1:0]      sum_full;
    logic [BOUND_W-1:0] sum_wide;
    acc_bounds_t        bnd;
    logic               over_hi;
    logic               over_lo;

    assign ext_a    = {{2{is_signed & op_a[ACC_WIDTH-1]}}, op_a};
    assign ext_b    = {{2{is_signed & op_b[ACC_WIDTH-1]}}, op_b};
    assign ext_c    = {{2{is_signed & op_c[ACC_WIDTH-1]}}, op_c};
    assign sum_full = ext_a + ext_b + ext_c;

    // In unsigned mode the guard bits are magnitude, so zero-extend then.
    assign sum_wide = {{(BOUND_W-SW){is_signed & sum_full[SW-1]}}, sum_full};
    assign bnd      = acc_bounds(ACC_WIDTH, is_signed);

    // Range check, then either clamp or wrap to the low ACC_WIDTH bits.
    always_comb begin
        over_hi = 1'b0;
        over_lo = 1'b0;
        result  = sum_full[ACC_WIDTH-1:0];
        if (is_signed) begin
            over_hi = $signed(sum_wide) > $signed(bnd.max_v);
            over_lo = $signed(sum_wide) < $signed(bnd.min_v);
        end else begin
            over_hi = sum_wide > bnd.max_v;
        end
        if (sat_en && over_hi) begin
            result = bnd.max_v[ACC_WIDTH-1:0];
        end else if (sat_en && over_lo) begin
            result = bnd.min_v[ACC_WIDTH-1:0];
        end
        ovf = over_hi | over_lo;
    end

endmodule

// File: rtl/dsp_mac_bel.sv
// Configurable multiply-accumulate BEL with optional input registers,
// signed/unsigned arithmetic, accumulation, cascade input and saturation.
module dsp_mac_bel
    import dsp_mac_pkg::*;
#(
    parameter int A_WIDTH      = 8,
    parameter int B_WIDTH      = 8,
    parameter int ACC_WIDTH    = 20,
    parameter int NoConfigBits = 6
) (
    input  logic                    UserCLK,
    input  logic                    UserRST_n,
    input  logic [A_WIDTH-1:0]      A,
    input  logic [B_WIDTH-1:0]      B,
    input  logic                    CE,
    input  logic                    CLR,
    input  logic [ACC_WIDTH-1:0]    CASC_IN,
    output logic [ACC_WIDTH-1:0]    CASC_OUT,
    output logic [ACC_WIDTH-1:0]    Q,
    output logic                    OVF,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    localparam int PW = A_WIDTH + B_WIDTH;

    if (ACC_WIDTH < PW) begin : g_bad_acc_width
        $error("dsp_mac_bel: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
    if (NoConfigBits != NUM_CONFIG_BITS) begin : g_bad_cfg_bits
        $error("dsp_mac_bel: NoConfigBits must be 6");
    end
    if (ACC_WIDTH + 2 > BOUND_W) begin : g_bad_bound_width
        $error("dsp_mac_bel: ACC_WIDTH too large for bound arithmetic");
    end

    logic                 is_signed;
    logic [A_WIDTH-1:0]   a_reg;
    logic [B_WIDTH-1:0]   b_reg;
    logic [A_WIDTH-1:0]   a_op;
    logic [B_WIDTH-1:0]   b_op;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_sel;
    logic [ACC_WIDTH-1:0] casc_sel;
    logic [ACC_WIDTH-1:0] q_reg;
    logic [ACC_WIDTH-1:0] q_next;
    logic                 ovf_reg;
    logic                 add_ovf;

    assign is_signed = ConfigBits[CFG_SIGNED];

    // Operand registers; they follow CE only, CLR touches the accumulator alone.
    always_ff @(posedge UserCLK) begin
        if (!UserRST_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (CE) begin
            a_reg <= A;
            b_reg <= B;
        end
    end

    // Each operand independently registered or bypassed; mixed settings skew them.
    assign a_op = ConfigBits[CFG_AREG] ? a_reg : A;
    assign b_op = ConfigBits[CFG_BREG] ? b_reg : B;

    // Extending both operands to the product width lets one multiplier serve
    // both modes: the low PW bits of the product are correct either way.
    assign a_ext = {{B_WIDTH{is_signed & a_op[A_WIDTH-1]}}, a_op};
    assign b_ext = {{A_WIDTH{is_signed & b_op[B_WIDTH-1]}}, b_op};
    assign prod  = a_ext * b_ext;

    assign prod_ext[PW-1:0] = prod;
    for (genvar gi = PW; gi < ACC_WIDTH; gi++) begin : g_prod_ext
        assign prod_ext[gi] = is_signed & prod[PW-1];
    end

    assign acc_sel  = ConfigBits[CFG_ACC_EN]  ? q_reg   : '0;
    assign casc_sel = ConfigBits[CFG_CASC_EN] ? CASC_IN : '0;

    dsp_mac_addsat #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_addsat (
        .op_a      (prod_ext),
        .op_b      (acc_sel),
        .op_c      (casc_sel),
        .is_signed (is_signed),
        .sat_en    (ConfigBits[CFG_SAT]),
        .result    (q_next),
        .ovf       (add_ovf)
    );

    // Accumulator and sticky overflow: reset, then CLR, then CE, else hold.
    always_ff @(posedge UserCLK) begin
        if (!UserRST_n) begin
            q_reg   <= '0;
            ovf_reg <= 1'b0;
        end else if (CLR) begin
            q_reg   <= '0;
            ovf_reg <= 1'b0;
        end else if (CE) begin
            q_reg   <= q_next;
            ovf_reg <= ovf_reg | add_ovf;
        end
    end

    assign Q        = q_reg;
    assign CASC_OUT = q_reg;
    assign OVF      = ovf_reg;

endmodule

// File: tb/tb_dsp_mac_bel.sv
// Self-checking bench for dsp_mac_bel: two cascaded instances driven by
// directed steps and random traffic, compared against an arithmetic model.
module tb_dsp_mac_bel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        ce;
    logic        clr;
    logic [19:0] casc0;
    logic [5:0]  cfg0;
    logic [5:0]  cfg1;

    logic [19:0] q0, q1, co0, co1;
    logic        ovf0, ovf1;

    int vectors    = 0;
    int miscompares = 0;

    // Model state per instance: operand registers, accumulator, overflow flag
    logic [7:0]  m_a   [2];
    logic [7:0]  m_b   [2];
    logic [19:0] m_q   [2];
    logic        m_ovf [2];
    logic [7:0]  n_a   [2];
    logic [7:0]  n_b   [2];
    logic [19:0] n_q   [2];
    logic        n_ovf [2];

    always #5 clk = ~clk;

    dsp_mac_bel u_low (
        .UserCLK    (clk),
        .UserRST_n  (rst_n),
        .A          (a_in),
        .B          (b_in),
        .CE         (ce),
        .CLR        (clr),
        .CASC_IN    (casc0),
        .CASC_OUT   (co0),
        .Q          (q0),
        .OVF        (ovf0),
        .ConfigBits (cfg0)
    );

    dsp_mac_bel u_high (
        .UserCLK    (clk),
        .UserRST_n  (rst_n),
        .A          (a_in),
        .B          (b_in),
        .CE         (ce),
        .CLR        (clr),
        .CASC_IN    (co0),
        .CASC_OUT   (co1),
        .Q          (q1),
        .OVF        (ovf1),
        .ConfigBits (cfg1)
    );

    task automatic chk20(input string tag, input logic [19:0] got, input logic [19:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    // Value of the next clock for instance k, computed with plain integer math.
    task automatic model_calc(input int k, input logic [5:0] cfg, input logic [19:0] casc);
        logic [7:0]  aop, bop;
        longint      av, bv, qv, cv, s, hi, lo, r;
        logic        ov;
        logic [19:0] res;
        aop = cfg[0] ? m_a[k] : a_in;
        bop = cfg[1] ? m_b[k] : b_in;
        if (cfg[2]) begin
            av = longint'($signed(aop));
            bv = longint'($signed(bop));
            qv = longint'($signed(m_q[k]));
            cv = longint'($signed(casc));
            hi = (longint'(1) << 19) - 1;
            lo = -(longint'(1) << 19);
        end else begin
            av = longint'(aop);
            bv = longint'(bop);
            qv = longint'(m_q[k]);
            cv = longint'(casc);
            hi = (longint'(1) << 20) - 1;
            lo = 0;
        end
        s  = av * bv + (cfg[3] ? qv : 0) + (cfg[4] ? cv : 0);
        ov = (s > hi) || (s < lo);
        r  = s;
        if (ov && cfg[5]) r = (s > hi) ? hi : lo;
        res = r[19:0];

        n_a[k] = m_a[k]; n_b[k] = m_b[k]; n_q[k] = m_q[k]; n_ovf[k] = m_ovf[k];
        if (!rst_n) begin
            n_a[k] = '0; n_b[k] = '0; n_q[k] = '0; n_ovf[k] = 1'b0;
        end else begin
            if (ce) begin
                n_a[k] = a_in;
                n_b[k] = b_in;
            end
            if (clr) begin
                n_q[k] = '0; n_ovf[k] = 1'b0;
            end else if (ce) begin
                n_q[k] = res; n_ovf[k] = m_ovf[k] | ov;
            end
        end
    endtask

    // One clock: predict both instances, advance, then compare everything.
    task automatic step();
        model_calc(0, cfg0, casc0);
        model_calc(1, cfg1, m_q[0]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_a[k] = n_a[k]; m_b[k] = n_b[k]; m_q[k] = n_q[k]; m_ovf[k] = n_ovf[k];
        end
        chk20("q_low", q0, m_q[0]);
        chk1("ovf_low", ovf0, m_ovf[0]);
        chk20("casc_out_low", co0, m_q[0]);
        chk20("q_high", q1, m_q[1]);
        chk1("ovf_high", ovf1, m_ovf[1]);
        $display("t=%0t cfg=%02h/%02h rst_n=%0b ce=%0b clr=%0b a=%02h b=%02h casc=%05h -> q0=%05h ovf0=%0b q1=%05h ovf1=%0b",
                 $time, cfg0, cfg1, rst_n, ce, clr, a_in, b_in, casc0, q0, ovf0, q1, ovf1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_a[k] = '0; m_b[k] = '0; m_q[k] = '0; m_ovf[k] = 1'b0;
        end
        rst_n = 1'b0; a_in = 8'd5; b_in = 8'd7; ce = 1'b1; clr = 1'b0;
        casc0 = '0; cfg0 = 6'h00; cfg1 = 6'h00;

        // Reset / basic
        step(); step();
        chk20("reset_q", q0, 20'd0);
        chk1("reset_ovf", ovf0, 1'b0);
        rst_n = 1'b1;
        step();
        chk20("basic_35", q0, 20'd35);

        // Signed two-stage latency, starting from zeroed operand registers
        a_in = 8'd0; b_in = 8'd0;
        step();
        cfg0 = 6'b000111; a_in = 8'hFD; b_in = 8'd4;
        step();
        chk20("signed_lat1", q0, 20'd0);
        step();
        chk20("signed_lat2", q0, 20'hFFFF4);

        // Accumulate, hold with CE=0, clear with CE=0
        cfg0 = 6'b001000; clr = 1'b1;
        step();
        clr = 1'b0; a_in = 8'd10; b_in = 8'd10;
        repeat (5) step();
        chk20("acc_500", q0, 20'd500);
        ce = 1'b0;
        repeat (3) step();
        chk20("hold_500", q0, 20'd500);
        clr = 1'b1;
        step();
        chk20("clr_no_ce", q0, 20'd0);
        clr = 1'b0; ce = 1'b1;

        // Signed saturation, then one wrapping step from the clamped value
        cfg0 = 6'b101100; a_in = 8'd127; b_in = 8'd127;
        repeat (34) step();
        chk20("sat_clamp", q0, 20'd524287);
        chk1("sat_ovf", ovf0, 1'b1);
        cfg0 = 6'b001100;
        step();
        chk20("wrap_value", q0, 20'h83F00);
        chk1("wrap_ovf", ovf0, 1'b1);

        // Cascade: lower adds CASC_IN, upper adds lower's registered result
        clr = 1'b1;
        step();
        clr = 1'b0; cfg0 = 6'b010000; cfg1 = 6'b010000;
        casc0 = 20'd1000; a_in = 8'd2; b_in = 8'd3;
        step();
        chk20("casc_low", q0, 20'd1006);
        step();
        chk20("casc_high", q1, 20'd1012);

        // Reach Q=300 with OVF set, then reset mid-operation
        cfg1 = 6'b000000; clr = 1'b1;
        step();
        clr = 1'b0; cfg0 = 6'b011100; casc0 = 20'h7FFFF; a_in = 8'd1; b_in = 8'd1;
        step();
        a_in = 8'd7; b_in = 8'd43;
        step();
        chk20("pre_reset_300", q0, 20'd300);
        chk1("pre_reset_ovf", ovf0, 1'b1);
        rst_n = 1'b0;
        step();
        chk20("mid_reset_q", q0, 20'd0);
        chk1("mid_reset_ovf", ovf0, 1'b0);
        rst_n = 1'b1; cfg0 = 6'b000000; a_in = 8'd1; b_in = 8'd1;
        step();
        chk20("post_reset_1", q0, 20'd1);

        // Random traffic across all configurations
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                cfg0 = 6'($urandom);
                cfg1 = 6'($urandom);
            end
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            casc0 = 20'($urandom);
            ce    = ($urandom_range(0, 9) < 8);
            clr   = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
